fpa_op_sequencer: RTL



---
 rtl/fpa_pkg.sv | 31 +++
 rtl/fpa_op_fifo.sv | 63 ++++++
 rtl/fpa_op_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// Shared FP8 field layout, exception code and sequencer state encoding
// for the FP8 adder issue stage.
package fpa_pkg;

    localparam int FP8_W  = 8;
    localparam int EXP_W  = 4;
    localparam int MANT_W = 3;
    localparam int EXC_W  = 4;

    localparam logic [EXC_W-1:0] EXC_TIMEOUT = 4'hF;

    // sign[7], exponent[6:3], mantissa[2:0]
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp8_t;

    typedef struct packed {
        fp8_t a;
        fp8_t b;
    } fp8_pair_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } seq_state_e;

endpackage

// File: rtl/fpa_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, pointers wrap naturally.
module fpa_op_fifo
    import fpa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  fp8_pair_t              wdata_i,
    output fp8_pair_t              rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fp8_pair_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpa_op_sequencer.sv
// Issue stage for the FP8 adder: buffers operand pairs, starts one add at
// a time, and holds each result (or watchdog abort) until consumed.
module fpa_op_sequencer
    import fpa_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP8_W-1:0]       in_a,
    input  logic [FP8_W-1:0]       in_b,
    output logic [FP8_W-1:0]       fpa_a,
    output logic [FP8_W-1:0]       fpa_b,
    output logic                   fpa_start,
    input  logic                   fpa_done,
    input  logic [FP8_W-1:0]       fpa_ans,
    input  logic [EXC_W-1:0]       fpa_except,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP8_W-1:0]       out_ans,
    output logic [EXC_W-1:0]       out_except,
    output logic                   out_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    seq_state_e       state_q, state_d;
    fp8_pair_t        opnd_q, opnd_d;
    logic [7:0]       timer_q, timer_d, timer_inc;
    logic [FP8_W-1:0] ans_q, ans_d;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic             tmo_q, tmo_d;
    fp8_pair_t        fifo_head;
    logic             fifo_full, fifo_empty;

    fpa_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (clr),
        .push_i  (in_valid),
        .pop_i   (state_q == S_IDLE),
        .wdata_i ({in_a, in_b}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        timer_d   = timer_q;
        ans_d     = ans_q;
        exc_d     = exc_q;
        tmo_d     = tmo_q;
        timer_inc = timer_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    opnd_d  = fifo_head;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_inc;
                // A done in the final allowed cycle still wins over abort
                if (fpa_done) begin
                    ans_d   = fpa_ans;
                    exc_d   = fpa_except;
                    tmo_d   = 1'b0;
                    state_d = S_HOLD;
                end else if (timer_inc == TO_LIM) begin
                    ans_d   = '0;
                    exc_d   = EXC_TIMEOUT;
                    tmo_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            opnd_q  <= '0;
            timer_q <= '0;
            ans_q   <= '0;
            exc_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            timer_q <= timer_d;
            ans_q   <= ans_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign fpa_a       = opnd_q.a;
    assign fpa_b       = opnd_q.b;
    assign fpa_start   = (state_q == S_ISSUE);
    assign out_valid   = (state_q == S_HOLD);
    assign busy        = (state_q != S_IDLE);
    assign out_ans     = ans_q;
    assign out_except  = exc_q;
    assign out_timeout = tmo_q;

endmodule
